// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes, master FSM states and protection default
package axi_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master behind a valid/ready command/response port
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  state_e state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign aw_done_n = (state == WR_ADDR_DATA) && (aw_done || aw_hs);
  assign w_done_n  = (state == WR_ADDR_DATA) && (w_done || w_hs);
  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;
  // state register plus per-channel done flags for the write address/data phase
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end
  // next-state decode; the write phase ends once both AW and W have handshaken
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (cmd_hs) state_n = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_done_n && w_done_n) state_n = WR_RESP;
      WR_RESP:      if (b_hs) state_n = RSP;
      RD_ADDR:      if (ar_hs) state_n = RD_DATA;
      RD_DATA:      if (r_hs) state_n = RSP;
      RSP:          if (rsp_hs) state_n = IDLE;
      default:      state_n = IDLE;
    endcase
  end
  // output decode from the next state so every control output can be registered
  always_comb begin
    cmd_ready_d = state_n == IDLE;
    awvalid_d   = (state_n == WR_ADDR_DATA) && !aw_done_n;
    wvalid_d    = (state_n == WR_ADDR_DATA) && !w_done_n;
    bready_d    = state_n == WR_RESP;
    arvalid_d   = state_n == RD_ADDR;
    rready_d    = state_n == RD_DATA;
    rsp_valid_d = state_n == RSP;
  end
  // registered outputs; payloads load only on their handshakes so they hold while valid is high
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_araddr  <= '0;
    end else begin
      cmd_ready     <= cmd_ready_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      if (cmd_hs && cmd_write) begin
        m_axi_awaddr <= cmd_addr;
        m_axi_wdata  <= cmd_wdata;
        m_axi_wstrb  <= cmd_wstrb;
      end
      if (cmd_hs && !cmd_write) m_axi_araddr <= cmd_addr;
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
      end
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed scoreboard bench with a latency-configurable AXI4-Lite responder
module tb_axi_lite_master;
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;
  int checks = 0, errors = 0;
  rsp_t exp_q[$];
  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, rsp_lat = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, rsp_wait = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, aw_hi = 0, w_hi = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  logic [31:0] exp_awaddr = '0, exp_wdata = '0, exp_araddr = '0;
  logic [3:0]  exp_wstrb = '0;
  logic        hold_pending = 1'b0, after_hs = 1'b0;
  rsp_t        held;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // responder and rsp_ready driver: update just after each rising edge from the counters
  always @(posedge aclk) begin
    #1;
    m_axi_awready = m_axi_awvalid && aw_wait >= aw_lat;
    m_axi_wready  = m_axi_wvalid && w_wait >= w_lat;
    m_axi_bvalid  = aw_cnt > b_cnt && w_cnt > b_cnt;
    m_axi_bresp   = cfg_bresp;
    m_axi_arready = m_axi_arvalid && ar_wait >= ar_lat;
    m_axi_rvalid  = ar_cnt > r_cnt && r_wait >= r_lat;
    m_axi_rdata   = cfg_rdata;
    m_axi_rresp   = cfg_rresp;
    rsp_ready     = rsp_valid && rsp_wait >= rsp_lat;
  end

  // observer on the falling edge: channel bookkeeping, protocol checks and the response scoreboard
  always @(negedge aclk) begin
    rsp_t e;
    aw_hi += int'(m_axi_awvalid);
    w_hi  += int'(m_axi_wvalid);
    if (m_axi_awvalid) check("awaddr_stable", m_axi_awaddr, exp_awaddr);
    if (m_axi_awvalid && m_axi_awready) begin
      aw_cnt++; aw_wait = 0;
      check("awprot", {29'd0, m_axi_awprot}, 32'd0);
    end else if (m_axi_awvalid) aw_wait++;
    else aw_wait = 0;
    if (m_axi_wvalid) begin
      check("wdata_stable", m_axi_wdata, exp_wdata);
      check("wstrb_stable", {28'd0, m_axi_wstrb}, {28'd0, exp_wstrb});
    end
    if (m_axi_wvalid && m_axi_wready) begin w_cnt++; w_wait = 0; end
    else if (m_axi_wvalid) w_wait++;
    else w_wait = 0;
    if (m_axi_bvalid && m_axi_bready) b_cnt++;
    if (m_axi_rvalid && m_axi_rready) begin r_cnt++; r_wait = 0; end
    else if (ar_cnt > r_cnt) r_wait++;
    else r_wait = 0;
    if (m_axi_arvalid) check("araddr_stable", m_axi_araddr, exp_araddr);
    if (m_axi_arvalid && m_axi_arready) begin
      ar_cnt++; ar_wait = 0;
      check("arprot", {29'd0, m_axi_arprot}, 32'd0);
    end else if (m_axi_arvalid) ar_wait++;
    else ar_wait = 0;
    if (m_axi_rready)
      check("rready_only_rd_data", {26'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid, cmd_ready}, 32'd0);
    if (m_axi_bready)
      check("bready_only_wr_resp", {26'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, rsp_valid, cmd_ready}, 32'd0);
    if (after_hs) begin
      check("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
      check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
      after_hs = 1'b0;
    end
    if (hold_pending) begin
      check("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      check("rsp_rdata_held", rsp_rdata, held.rdata);
      check("rsp_resp_held", {30'd0, rsp_resp}, {30'd0, held.resp});
    end
    hold_pending = 1'b0;
    if (rsp_valid) begin
      check("cmd_ready_during_rsp", {31'd0, cmd_ready}, 32'd0);
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=%h/%h required=none", rsp_rdata, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
        end
        after_hs = 1'b1;
        rsp_wait = 0;
      end else begin
        hold_pending = 1'b1;
        held.rdata = rsp_rdata;
        held.resp = rsp_resp;
        rsp_wait++;
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (cmd_ready) break;
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL cmd_accept_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] er, input logic [1:0] eresp);
    rsp_t e;
    if (wr) begin exp_awaddr = addr; exp_wdata = data; exp_wstrb = strb; end
    else exp_araddr = addr;
    e.rdata = er;
    e.resp = eresp;
    exp_q.push_back(e);
    issue(wr, addr, data, strb);
  endtask

  task automatic wait_done();
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
      if (n == 200) begin
        checks++; errors++;
        $display("FAIL rsp_timeout actual=%0d pending required=0", exp_q.size());
        break;
      end
    end
    @(negedge aclk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0, b0;
    @(negedge aclk);
    check("reset_valids", {24'd0, cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, 1'b0}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_awaddr", m_axi_awaddr, 32'd0);
    check("reset_wdata", m_axi_wdata, 32'd0);
    check("reset_araddr", m_axi_araddr, 32'd0);
    #2 areset = 1'b0;
    #1 check("cmd_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge aclk);
    check("cmd_ready_first_edge", {31'd0, cmd_ready}, 32'd1);
    aw0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    send(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    wait_done();
    check("w1_aw_cycles", aw_hi - aw0, 32'd1);
    check("w1_w_cycles", w_hi - w0, 32'd1);
    check("w1_b_count", b_cnt - b0, 32'd1);
    aw_lat = 3;
    aw0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    send(1'b1, 32'h8, 32'hCAFEF00D, 4'h3, 32'h0, 2'b00);
    wait_done();
    aw_lat = 0;
    check("w2_aw_cycles", aw_hi - aw0, 32'd4);
    check("w2_w_cycles", w_hi - w0, 32'd1);
    check("w2_b_count", b_cnt - b0, 32'd1);
    r_lat = 2; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    send(1'b0, 32'hC, 32'h0, 4'h0, 32'h12345678, 2'b00);
    wait_done();
    r_lat = 0;
    cfg_bresp = 2'b10;
    send(1'b1, 32'h10, 32'h55AA55AA, 4'hF, 32'h0, 2'b10);
    wait_done();
    cfg_bresp = 2'b00;
    cfg_rdata = 32'hA5A5A5A5;
    send(1'b0, 32'h14, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b00);
    wait_done();
    rsp_lat = 5; cfg_rdata = 32'h0BADCAFE; cfg_rresp = 2'b01;
    send(1'b0, 32'h18, 32'h0, 4'h0, 32'h0BADCAFE, 2'b01);
    wait_done();
    rsp_lat = 0; cfg_rresp = 2'b00;
    send(1'b1, 32'h1C, 32'h11223344, 4'h0, 32'h0, 2'b00);
    wait_done();
    ar_lat = 1000; exp_araddr = 32'h20;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge aclk);
    check("arvalid_before_reset", {31'd0, m_axi_arvalid}, 32'd1);
    #2 areset = 1'b1;
    #1;
    check("arvalid_async_clear", {31'd0, m_axi_arvalid}, 32'd0);
    check("cmd_ready_async_clear", {31'd0, cmd_ready}, 32'd0);
    repeat (3) begin
      @(negedge aclk);
      check("no_rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
    end
    #2 areset = 1'b0;
    #1 check("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd0);
    @(negedge aclk);
    check("cmd_ready_edge_after_release", {31'd0, cmd_ready}, 32'd1);
    check("no_rsp_after_abandon", {31'd0, rsp_valid}, 32'd0);
    ar_lat = 0; cfg_rdata = 32'h600DF00D;
    send(1'b0, 32'h24, 32'h0, 4'h0, 32'h600DF00D, 2'b00);
    wait_done();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite master. Converts a simple valid/ready command port (read or write, one 32-bit word) into AXI4-Lite channel traffic and returns the response on a valid/ready response port. It sits between on-chip control logic (sequencers, CPU-less config engines) and the team's AXI4-Lite register slaves.

## Interface
- ADDR_W, 32, address width of cmd_addr and m_axi_awaddr/m_axi_araddr
- DATA_W, 32, data width; wstrb width is DATA_W/8
- aclk  input  1  sole clock; all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  input / output  1  command handshake
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  byte address, passed through unmodified
- cmd_wdata / cmd_wstrb  input  DATA_W / DATA_W/8  write data and byte strobes (ignored for reads)
- rsp_valid / rsp_ready  output / input  1  response handshake
- rsp_rdata  output  DATA_W  read data; 0 for writes
- rsp_resp  output  2  raw BRESP or RRESP
- m_axi_awaddr, m_axi_awprot, m_axi_awvalid  output  ADDR_W, 3, 1  AW channel
- m_axi_awready  input  1
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid  output  DATA_W, DATA_W/8, 1  W channel
- m_axi_wready  input  1
- m_axi_bresp, m_axi_bvalid  input  2, 1;  m_axi_bready  output  1  B channel
- m_axi_araddr, m_axi_arprot, m_axi_arvalid  output  ADDR_W, 3, 1;  m_axi_arready  input  1  AR channel
- m_axi_rdata, m_axi_rresp, m_axi_rvalid  input  DATA_W, 2, 1;  m_axi_rready  output  1  R channel

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write. Go to WR_ADDR_DATA (write) or RD_ADDR (read).
- WR_ADDR_DATA: awvalid and wvalid are both asserted on entry. Each drops independently on its own handshake, and a done flag records it.
  - When both flags are set (including both handshakes on the same edge), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp, go to RSP.
- RD_ADDR: arvalid=1 until arready, then RD_DATA. RD_DATA: rready=1. On rvalid, capture rdata/rresp, go to RSP.
- RSP: rsp_valid=1 and held with stable data until rsp_ready, then IDLE.
- Exactly one transaction in flight. awprot/arprot are constant 3'b000.
- Address/data outputs are stable while their valid is high. A valid never deasserts before its handshake.
- wstrb=0 is issued as-is. Response codes pass through uninterpreted (SLVERR/DECERR are not retried).

## Timing
- All outputs are registered.
- Reset value of every output:
  - 0 for all valids, readies, cmd_ready, rsp_*, and all m_axi address/data/strb outputs.
  - cmd_ready rises on the first aclk edge after areset deasserts.
- Command accepted at edge N → awvalid/wvalid (or arvalid) high from edge N+1.
- Response handshake at edge M → rsp_valid high from edge M+1.
- rsp_ready handshake at edge K → cmd_ready high from edge K+1.
- Master overhead is 3 cycles beyond slave latency. Minimum command-to-command spacing with a zero-wait slave is 5 cycles (write) and 5 cycles (read).
- areset asserted mid-transaction: all outputs clear immediately and the FSM returns to IDLE. The transaction is abandoned with no rsp_valid.
- bready/rready are never high outside WR_RESP/RD_DATA.

## Structure
- Shared package axi_lite_pkg holds:
  - the resp enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11;
  - the master FSM state typedef;
  - the constant AXI_PROT_DEFAULT = 3'b000.
- Single flat module; no sub-module is warranted.

## Test plan
- Write 0x4 data 0xDEADBEEF strb 0xF to an always-ready responder (bresp OKAY) → AW and W handshake on the same edge, one B, then rsp_resp=00 and rsp_rdata=0.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held with stable 0x8 for 4 cycles, single B accepted.
- Read 0xC, responder returns 0x12345678 after 2 wait cycles → rsp_rdata=0x12345678, rsp_resp=00, rready high only in RD_DATA.
- Responder returns bresp=SLVERR on write to 0x10 → rsp_resp=2'b10, FSM back to IDLE, next command accepted normally.
- rsp_ready held low 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready stays 0 until the cycle after the handshake.
- areset pulsed while arvalid high → arvalid/cmd_ready drop immediately, no rsp_valid, cmd_ready=1 one edge after release.
